imem_boot_loader: RTL and testbench

- Boot-time program loader upstream of the instruction memory.
- Receives a byte stream from a host link (UART receiver or testbench) and assembles big-endian 32-bit instruction words.
- Writes each word to the instruction memory write port and holds the single-cycle core in reset until a complete, checksum-verified image is loaded.
- Releases the core to fetch from word address 0.

---
 rtl/imem_boot_loader.sv | 146 ++++++++++++++
 tb/tb_imem_boot_loader.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Boot loader: assembles big-endian words from a host byte stream, writes them to
// instruction memory and releases the core once the XOR checksum matches.
// Optional macro IMEM_BOOT_RELOAD_EN adds a reload input to restart from DONE/ERR.
module imem_boot_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_WORDS  = 256
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef IMEM_BOOT_RELOAD_EN
    input  logic                  reload,
`endif
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    localparam logic [2:0] S_LEN_HI = 3'd0;
    localparam logic [2:0] S_LEN_LO = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_CSUM   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;

    logic [2:0]            state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [15:0]           wcnt_q, wcnt_d;
    logic [1:0]            bcnt_q, bcnt_d;
    logic [23:0]           asm_q, asm_d;
    logic [7:0]            csum_q, csum_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;

    logic        accept;
    logic [15:0] len_full;

    assign rx_ready   = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                        (state_q == S_DATA)   || (state_q == S_CSUM);
    assign accept     = rx_valid && rx_ready;
    assign len_full   = {len_q[15:8], rx_data};
    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign cpu_hold   = (state_q != S_DONE);
    assign done       = (state_q == S_DONE);
    assign error      = (state_q == S_ERR);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        wcnt_d  = wcnt_q;
        bcnt_d  = bcnt_q;
        asm_d   = asm_q;
        csum_d  = csum_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_LEN_HI: begin
                if (accept) begin
                    len_d   = {rx_data, 8'h00};
                    csum_d  = csum_q ^ rx_data;
                    state_d = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d  = len_full;
                    csum_d = csum_q ^ rx_data;
                    if (len_full > 16'(MAX_WORDS))
                        state_d = S_ERR;
                    else if (len_full == 16'd0)
                        state_d = S_CSUM;
                    else
                        state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    csum_d = csum_q ^ rx_data;
                    bcnt_d = bcnt_q + 2'd1;
                    if (bcnt_q == 2'd3) begin
                        // Word complete: register the write so it lands next cycle.
                        we_d    = 1'b1;
                        addr_d  = wcnt_q[ADDR_WIDTH-1:0];
                        wdata_d = {asm_q, rx_data};
                        wcnt_d  = wcnt_q + 16'd1;
                        if (wcnt_q == len_q - 16'd1)
                            state_d = S_CSUM;
                    end else begin
                        asm_d = {asm_q[15:0], rx_data};
                    end
                end
            end
            S_CSUM: begin
                if (accept)
                    state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
            end
            S_DONE, S_ERR: begin
`ifdef IMEM_BOOT_RELOAD_EN
                if (reload) begin
                    state_d = S_LEN_HI;
                    len_d   = 16'd0;
                    wcnt_d  = 16'd0;
                    bcnt_d  = 2'd0;
                    asm_d   = 24'd0;
                    csum_d  = 8'd0;
                end
`endif
            end
            default: state_d = S_ERR;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_LEN_HI;
            len_q   <= 16'd0;
            wcnt_q  <= 16'd0;
            bcnt_q  <= 2'd0;
            asm_q   <= 24'd0;
            csum_q  <= 8'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            wcnt_q  <= wcnt_d;
            bcnt_q  <= bcnt_d;
            asm_q   <= asm_d;
            csum_q  <= csum_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: expected writes are queued as bytes are
// driven and checked when imem_we fires.
module tb_imem_boot_loader;

    logic        clk;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;
`ifdef IMEM_BOOT_RELOAD_EN
    logic        reload;
`endif

    int tests;
    int fails;
    int wr_count;
    logic [39:0] sb[$];
    logic [7:0]  stream[$];

    imem_boot_loader #(.ADDR_WIDTH(8), .MAX_WORDS(256)) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef IMEM_BOOT_RELOAD_EN
        .reload     (reload),
`endif
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset === 1'b1 && imem_we === 1'b1) begin
            logic [39:0] exp;
            wr_count++;
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: got addr=%0h data=%08h, required no write", imem_addr, imem_wdata);
            end else begin
                exp = sb.pop_front();
                if ({imem_addr, imem_wdata} !== exp) begin
                    fails++;
                    $display("FAIL write: got addr=%0h data=%08h, required addr=%0h data=%08h",
                             imem_addr, imem_wdata, exp[39:32], exp[31:0]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        reset    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (rx_ready !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: rx_ready=%b, required 1 within 20 cycles", rx_ready);
        end else begin
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
    endtask

    task automatic send_stream(input bit bubbles);
        for (int i = 0; i < stream.size(); i++) begin
            if (bubbles && i != 0) begin
                int g;
                g = $urandom_range(1, 5);
                repeat (g) begin
                    @(posedge clk);
                    #1;
                end
            end
            send_byte(stream[i]);
        end
    endtask

    task automatic load_good(input logic [7:0] last);
        stream = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A, last};
    endtask

    task automatic check_done_state(input string tag);
        tests++;
        if (done !== 1'b1 || cpu_hold !== 1'b0 || error !== 1'b0 || rx_ready !== 1'b0) begin
            fails++;
            $display("FAIL %s_done: got done=%b hold=%b err=%b rdy=%b, required 1 0 0 0",
                     tag, done, cpu_hold, error, rx_ready);
        end
    endtask

    task automatic check_sb_empty(input string tag);
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL %s_writes: %0d expected writes missing, required 0", tag, sb.size());
        end
        sb.delete();
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (rx_ready !== 1'b1 || imem_we !== 1'b0 || imem_addr !== 8'h00 || imem_wdata !== 32'h0 ||
            cpu_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: got rdy=%b we=%b addr=%0h data=%08h hold=%b done=%b err=%b, required 1 0 0 0 1 0 0",
                     rx_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if (rx_ready !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: got rdy=%b hold=%b done=%b, required 1 1 0", rx_ready, cpu_hold, done);
        end
    endtask

    task automatic test_good_image();
        apply_reset();
        sb.push_back({8'h00, 32'h20080005});
        sb.push_back({8'h01, 32'h2009000A});
        load_good(8'h0C);
        send_stream(1'b0);
        check_done_state("good");
        tests++;
        if (imem_addr !== 8'h01 || imem_wdata !== 32'h2009000A) begin
            fails++;
            $display("FAIL good_hold_outputs: got addr=%0h data=%08h, required 1 2009000a", imem_addr, imem_wdata);
        end
        check_sb_empty("good");
    endtask

    task automatic test_bad_checksum();
        apply_reset();
        sb.push_back({8'h00, 32'h20080005});
        sb.push_back({8'h01, 32'h2009000A});
        load_good(8'h0D);
        send_stream(1'b0);
        tests++;
        if (error !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0 || rx_ready !== 1'b0) begin
            fails++;
            $display("FAIL badcsum_state: got err=%b hold=%b done=%b rdy=%b, required 1 1 0 0",
                     error, cpu_hold, done, rx_ready);
        end
        check_sb_empty("badcsum");
    endtask

    task automatic test_oversize();
        int w0;
        apply_reset();
        w0 = wr_count;
        stream = '{8'h01, 8'h01};
        send_stream(1'b0);
        tests++;
        if (error !== 1'b1 || done !== 1'b0 || rx_ready !== 1'b0 || cpu_hold !== 1'b1) begin
            fails++;
            $display("FAIL oversize_state: got err=%b done=%b rdy=%b hold=%b, required 1 0 0 1",
                     error, done, rx_ready, cpu_hold);
        end
        repeat (5) @(posedge clk);
        #1;
        tests++;
        if (wr_count != w0) begin
            fails++;
            $display("FAIL oversize_writes: got %0d writes, required 0", wr_count - w0);
        end
    endtask

    task automatic test_empty_image();
        int w0;
        apply_reset();
        w0 = wr_count;
        stream = '{8'h00, 8'h00, 8'h00};
        send_stream(1'b0);
        check_done_state("empty");
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (wr_count != w0) begin
            fails++;
            $display("FAIL empty_writes: got %0d writes, required 0", wr_count - w0);
        end
    endtask

    task automatic test_bubbles_and_midreset();
        apply_reset();
        sb.push_back({8'h00, 32'h20080005});
        sb.push_back({8'h01, 32'h2009000A});
        load_good(8'h0C);
        send_stream(1'b1);
        check_done_state("bubbles");
        check_sb_empty("bubbles");

        apply_reset();
        sb.push_back({8'h00, 32'h20080005});
        load_good(8'h0C);
        for (int i = 0; i < 6; i++) send_byte(stream[i]);
        @(negedge clk);
        #1;
        reset = 1'b0;
        #2;
        tests++;
        if (cpu_hold !== 1'b1 || imem_addr !== 8'h00 || rx_ready !== 1'b1) begin
            fails++;
            $display("FAIL midreset_state: got hold=%b addr=%0h rdy=%b, required 1 0 1", cpu_hold, imem_addr, rx_ready);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        sb.push_back({8'h00, 32'h20080005});
        sb.push_back({8'h01, 32'h2009000A});
        send_stream(1'b1);
        check_done_state("midreset");
        check_sb_empty("midreset");
    endtask

`ifdef IMEM_BOOT_RELOAD_EN
    task automatic test_reload();
        apply_reset();
        reload = 1'b0;
        sb.push_back({8'h00, 32'h20080005});
        sb.push_back({8'h01, 32'h2009000A});
        load_good(8'h0C);
        send_stream(1'b0);
        check_done_state("reload_pre");
        check_sb_empty("reload_pre");
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
        tests++;
        if (cpu_hold !== 1'b1 || rx_ready !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
            fails++;
            $display("FAIL reload_restart: got hold=%b rdy=%b done=%b err=%b, required 1 1 0 0",
                     cpu_hold, rx_ready, done, error);
        end
        sb.push_back({8'h00, 32'h12345678});
        stream = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
        send_stream(1'b0);
        check_done_state("reload");
        check_sb_empty("reload");
    endtask
`endif

    initial begin
        tests    = 0;
        fails    = 0;
        wr_count = 0;
`ifdef IMEM_BOOT_RELOAD_EN
        reload   = 1'b0;
`endif
        test_reset();
        test_good_image();
        test_bad_checksum();
        test_oversize();
        test_empty_image();
        test_bubbles_and_midreset();
`ifdef IMEM_BOOT_RELOAD_EN
        test_reload();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
